fifo_ctrl: RTL and testbench



---
 rtl/fifo_ctrl.sv | 99 +++++++++
 tb/tb_fifo_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for an 8-deep FIFO memory.
// Accepts push/pop requests, drives the memory write/read enables and addresses,
// and reports full/empty, programmable almost flags, a sticky error and data_valid.
module fifo_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W:0]   umbral_af,
  input  logic [ADDR_W:0]   umbral_ae,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error,
  output logic              data_valid
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              error_reg, error_next;
  logic              data_valid_reg;

  // Flags are pure functions of the registered occupancy and the live thresholds.
  always_comb begin
    full         = (count_reg == DEPTH_C);
    empty        = (count_reg == '0);
    almost_full  = (count_reg >= umbral_af);
    almost_empty = (count_reg <= umbral_ae);
  end

  // Request acceptance; a pop frees a slot so push is allowed at full when paired
  // with a pop. Nothing reaches the memory while reset is held.
  always_comb begin
    wr_en = push & (~full | pop) & ~reset;
    rd_en = pop & ~empty & ~reset;
  end

  // Next-state for pointers, occupancy and the sticky error flag.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    error_next  = error_reg;
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;  // wraps modulo DEPTH by natural overflow
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // Overflow: push into a full FIFO with no pop; underflow: any pop when empty.
    if ((push & full & ~pop) | (pop & empty)) begin
      error_next = 1'b1;
    end
  end

  // State registers; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      error_reg      <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      error_reg      <= error_next;
      data_valid_reg <= rd_en;  // memory read data appears one cycle after rd_en
    end
  end

  // Expose registered state.
  always_comb begin
    wr_ptr     = wr_ptr_reg;
    rd_ptr     = rd_ptr_reg;
    count      = count_reg;
    error      = error_reg;
    data_valid = data_valid_reg;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: table-driven vectors with a data_valid scoreboard queue, plus a
// short hand-written sequence for live threshold changes.
module tb_fifo_ctrl;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset, push, pop;
  logic [ADDR_W:0]   umbral_af, umbral_ae;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full, empty, almost_full, almost_empty, error, data_valid;

  fifo_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, psh, pp;
    logic [3:0] af, ae;
    logic       ewr, erd;  // expected enables before the edge
    logic [3:0] ecnt;      // expected count after the edge
    logic       eerr;      // expected error after the edge
  } vec_t;

  vec_t vecs[$];
  logic dv_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input int rst, input int psh, input int pp, input int af, input int ae,
                     input int ewr, input int erd, input int ecnt, input int eerr);
    vec_t v;
    v.rst = rst[0]; v.psh = psh[0]; v.pp = pp[0];
    v.af = af[3:0]; v.ae = ae[3:0];
    v.ewr = ewr[0]; v.erd = erd[0]; v.ecnt = ecnt[3:0]; v.eerr = eerr[0];
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  initial begin
    int   ewp, erp;
    logic dv_exp;

    // reset held two cycles with push=pop=1
    add(1,1,1,6,2, 0,0,0,0);
    add(1,1,1,6,2, 0,0,0,0);
    // fill: eight pushes
    for (int i = 1; i <= 8; i++) add(0,1,0,6,2, 1,0,i,0);
    // overflow push at full
    add(0,1,0,6,2, 0,0,8,1);
    // push+pop at full: both accepted, count unchanged
    add(0,1,1,6,2, 1,1,8,1);
    // drain: eight pops
    for (int i = 7; i >= 0; i--) add(0,0,1,6,2, 0,1,i,1);
    // underflow pop at empty
    add(0,0,1,6,2, 0,0,0,1);
    // reset clears error
    add(1,0,0,6,2, 0,0,0,0);
    // push+pop at empty: push only, underflow flagged
    add(0,1,1,6,2, 1,0,1,1);
    add(1,0,0,6,2, 0,0,0,0);
    // three pushes, one pop down to ae threshold, then push+pop mid-range
    for (int i = 1; i <= 3; i++) add(0,1,0,6,2, 1,0,i,0);
    add(0,0,1,6,2, 0,1,2,0);
    add(0,1,1,6,2, 1,1,2,0);
    // reset mid-operation
    add(1,0,0,6,2, 0,0,0,0);
    // thresholds at zero, then a push with af=1
    add(0,0,0,0,0, 0,0,0,0);
    add(0,1,0,1,0, 1,0,1,0);

    ewp = 0; erp = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; push = vecs[i].psh; pop = vecs[i].pp;
      umbral_af = vecs[i].af; umbral_ae = vecs[i].ae;
      #1;
      chk(i, "wr_en", int'(wr_en), int'(vecs[i].ewr));
      chk(i, "rd_en", int'(rd_en), int'(vecs[i].erd));
      dv_q.push_back(vecs[i].erd);
      if (vecs[i].rst) begin
        ewp = 0; erp = 0;
      end else begin
        ewp = (ewp + int'(vecs[i].ewr)) % DEPTH;
        erp = (erp + int'(vecs[i].erd)) % DEPTH;
      end
      @(posedge clk);
      #1;
      dv_exp = dv_q.pop_front();
      chk(i, "data_valid", int'(data_valid), int'(dv_exp));
      chk(i, "count", int'(count), int'(vecs[i].ecnt));
      chk(i, "error", int'(error), int'(vecs[i].eerr));
      chk(i, "wr_ptr", int'(wr_ptr), ewp);
      chk(i, "rd_ptr", int'(rd_ptr), erp);
      chk(i, "full", int'(full), int'(vecs[i].ecnt == 4'(DEPTH)));
      chk(i, "empty", int'(empty), int'(vecs[i].ecnt == 4'd0));
      chk(i, "almost_full", int'(almost_full), int'(vecs[i].ecnt >= vecs[i].af));
      chk(i, "almost_empty", int'(almost_empty), int'(vecs[i].ecnt <= vecs[i].ae));
      $display("[TB] vec %0d rst=%0b push=%0b pop=%0b -> wr_en=%0b rd_en=%0b count=%0d err=%0b dv=%0b",
               i, vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].ewr, vecs[i].erd,
               count, error, data_valid);
    end

    // live threshold changes with count=1 and no clock edge in between
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    umbral_af = 4'd1; #1;
    chk(100, "af_thr1", int'(almost_full), 1);
    umbral_af = 4'd2; #1;
    chk(101, "af_thr2", int'(almost_full), 0);
    umbral_ae = 4'd0; #1;
    chk(102, "ae_thr0", int'(almost_empty), 0);
    umbral_ae = 4'd1; #1;
    chk(103, "ae_thr1", int'(almost_empty), 1);
    umbral_af = 4'd8; umbral_ae = 4'd8; #1;
    chk(104, "af_thr8", int'(almost_full), 0);
    chk(105, "ae_thr8", int'(almost_empty), 1);
    $display("[TB] threshold sweep done at count=%0d", count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
